// File: rtl/wash_sequencer.sv
// -----------------------------------------------------------------------------
// wash_sequencer
//
// Washing-machine program sequencer. A start pulse in IDLE latches the program
// mode and steps the machine through FILL -> WASH -> RINSE -> SPIN -> DONE.
// Mode 00 goes straight to SPIN. Each phase lasts a whole number of 1 s ticks.
// The ticks come from an internal prescaler of TICK_DIV clk cycles.
//
// Optional feature (macro WASH_SEQ_OVERTIME_EN):
//   defined   - DONE keeps ticking and overtime counts ticks until ack
//               (saturates at 255).
//   undefined - overtime is tied to 0 and the prescaler is idle in DONE.
//
// Parameters
//   TICK_DIV  clk cycles per tick (>= 2)
//   SPIN_S    SPIN phase length in ticks (1..255)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   start      in   pulse: begin a program (accepted only in IDLE)
//   mode[1:0]  in   00 spin-only, 01 small, 10 medium, 11 big
//   pause      in   pulse: toggle paused while busy
//   abort      in   pulse: return to IDLE from any non-IDLE state
//   ack        in   pulse: release DONE
//   phase[2:0] out  IDLE=0 FILL=1 WASH=2 RINSE=3 SPIN=4 DONE=5
//   sec_left   out  ticks remaining in the current phase
//   water_lvl  out  thermometer water level, LSB first
//   busy       out  high in FILL..SPIN
//   paused     out  pause flag
//   done       out  high in DONE
//   overtime   out  ticks spent in DONE before ack
// -----------------------------------------------------------------------------
module wash_sequencer #(
   parameter int TICK_DIV = 100000000,
   parameter int SPIN_S   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] mode,
   input  logic       pause,
   input  logic       abort,
   input  logic       ack,
   output logic [2:0] phase,
   output logic [7:0] sec_left,
   output logic [7:0] water_lvl,
   output logic       busy,
   output logic       paused,
   output logic       done,
   output logic [7:0] overtime
);

   localparam int            PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
   localparam logic [7:0]    SPIN_DUR   = 8'(SPIN_S);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_WASH  = 3'd2,
      S_RINSE = 3'd3,
      S_SPIN  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t        state_reg,  state_next;
   logic [7:0]    sec_reg,    sec_next;
   logic [7:0]    water_reg,  water_next;
   logic          paused_reg, paused_next;
   logic [1:0]    mode_reg,   mode_next;
   logic [PW-1:0] presc_reg,  presc_next;
`ifdef WASH_SEQ_OVERTIME_EN
   logic [7:0]    ot_reg,     ot_next;
`endif

   logic       busy_int;
   logic       run;
   logic       tick;
   logic [7:0] water_shift;

   // Per-mode phase lengths (mode 00 never uses these).
   function automatic logic [7:0] fill_dur(input logic [1:0] m);
      case (m)
         2'b01:   fill_dur = 8'd2;
         2'b10:   fill_dur = 8'd4;
         default: fill_dur = 8'd8;
      endcase
   endfunction

   function automatic logic [7:0] wash_dur(input logic [1:0] m);
      case (m)
         2'b01:   wash_dur = 8'd4;
         2'b10:   wash_dur = 8'd6;
         default: wash_dur = 8'd8;
      endcase
   endfunction

   function automatic logic [7:0] rinse_dur(input logic [1:0] m);
      case (m)
         2'b01:   rinse_dur = 8'd3;
         2'b10:   rinse_dur = 8'd4;
         default: rinse_dur = 8'd5;
      endcase
   endfunction

   // Water level with one more light switched on from the LSB side.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_therm
         if (gi == 0) begin : g_lsb
            assign water_shift[gi] = 1'b1;
         end else begin : g_up
            assign water_shift[gi] = water_reg[gi-1];
         end
      end
   endgenerate

   assign busy_int = (state_reg == S_FILL) || (state_reg == S_WASH) ||
                     (state_reg == S_RINSE) || (state_reg == S_SPIN);

`ifdef WASH_SEQ_OVERTIME_EN
   assign run = (busy_int && !paused_reg) || (state_reg == S_DONE);
`else
   assign run = busy_int && !paused_reg;
`endif
   assign tick = run && (presc_reg == PRESC_MAX);

   always_comb begin
      state_next  = state_reg;
      sec_next    = sec_reg;
      water_next  = water_reg;
      paused_next = paused_reg;
      mode_next   = mode_reg;
      presc_next  = presc_reg;
`ifdef WASH_SEQ_OVERTIME_EN
      ot_next     = ot_reg;
`endif
      if (run) begin
         presc_next = tick ? '0 : presc_reg + PW'(1);
      end

      if (abort && (state_reg != S_IDLE)) begin
         state_next  = S_IDLE;
         sec_next    = 8'd0;
         water_next  = 8'd0;
         paused_next = 1'b0;
         presc_next  = '0;
`ifdef WASH_SEQ_OVERTIME_EN
         ot_next     = 8'd0;
`endif
      end else if (ack && (state_reg == S_DONE)) begin
         state_next = S_IDLE;
         sec_next   = 8'd0;
         presc_next = '0;
`ifdef WASH_SEQ_OVERTIME_EN
         ot_next    = 8'd0;
`endif
      end else begin
         // A pause pulse does not block a coincident tick: the tick was
         // qualified by the old paused_reg.
         if (busy_int && pause) begin
            paused_next = !paused_reg;
         end
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  mode_next  = mode;
                  presc_next = '0;
                  if (mode == 2'b00) begin
                     state_next = S_SPIN;
                     sec_next   = SPIN_DUR;
                  end else begin
                     state_next = S_FILL;
                     sec_next   = fill_dur(mode);
                  end
               end
            end
            S_FILL: begin
               if (tick) begin
                  water_next = water_shift;
                  if (sec_reg == 8'd1) begin
                     state_next = S_WASH;
                     sec_next   = wash_dur(mode_reg);
                  end else begin
                     sec_next = sec_reg - 8'd1;
                  end
               end
            end
            S_WASH: begin
               if (tick) begin
                  if (sec_reg == 8'd1) begin
                     state_next = S_RINSE;
                     sec_next   = rinse_dur(mode_reg);
                  end else begin
                     sec_next = sec_reg - 8'd1;
                  end
               end
            end
            S_RINSE: begin
               if (tick) begin
                  if (sec_reg == 8'd1) begin
                     state_next = S_SPIN;
                     sec_next   = SPIN_DUR;
                     water_next = 8'd0;
                  end else begin
                     sec_next = sec_reg - 8'd1;
                  end
               end
            end
            S_SPIN: begin
               if (tick) begin
                  if (sec_reg == 8'd1) begin
                     // DONE starts with a fresh tick period; the pause flag
                     // has no meaning once the machine is no longer busy.
                     state_next  = S_DONE;
                     sec_next    = 8'd0;
                     presc_next  = '0;
                     paused_next = 1'b0;
                  end else begin
                     sec_next = sec_reg - 8'd1;
                  end
               end
            end
            S_DONE: begin
`ifdef WASH_SEQ_OVERTIME_EN
               if (tick && (ot_reg != 8'hFF)) begin
                  ot_next = ot_reg + 8'd1;
               end
`endif
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= S_IDLE;
         sec_reg    <= 8'd0;
         water_reg  <= 8'd0;
         paused_reg <= 1'b0;
         mode_reg   <= 2'b00;
         presc_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         sec_reg    <= sec_next;
         water_reg  <= water_next;
         paused_reg <= paused_next;
         mode_reg   <= mode_next;
         presc_reg  <= presc_next;
      end
   end

`ifdef WASH_SEQ_OVERTIME_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ot_reg <= 8'd0;
      end else begin
         ot_reg <= ot_next;
      end
   end
   assign overtime = ot_reg;
`else
   assign overtime = 8'd0;
`endif

   assign phase     = state_reg;
   assign sec_left  = sec_reg;
   assign water_lvl = water_reg;
   assign busy      = busy_int;
   assign paused    = paused_reg;
   assign done      = (state_reg == S_DONE);

endmodule

// File: tb/tb_wash_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wash_sequencer
//
// Scoreboard bench for wash_sequencer (TICK_DIV=4, SPIN_S=3). Each accepted
// start pushes the expected phase entries (phase, sec_left, water_lvl, edge
// number) into a queue; a monitor pops and compares one entry per observed
// phase change. Direct checks cover reset, pause hold, abort, ignored
// start/ack, and overtime.
// -----------------------------------------------------------------------------
module tb_wash_sequencer;

   localparam int TD = 4;

   logic       clk;
   logic       rst;
   logic       start;
   logic [1:0] mode;
   logic       pause;
   logic       abort;
   logic       ack;
   logic [2:0] phase;
   logic [7:0] sec_left;
   logic [7:0] water_lvl;
   logic       busy;
   logic       paused;
   logic       done;
   logic [7:0] overtime;

   wash_sequencer #(.TICK_DIV(TD), .SPIN_S(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .pause     (pause),
      .abort     (abort),
      .ack       (ack),
      .phase     (phase),
      .sec_left  (sec_left),
      .water_lvl (water_lvl),
      .busy      (busy),
      .paused    (paused),
      .done      (done),
      .overtime  (overtime)
   );

   typedef struct {
      int ph;
      int sec;
      int wl;
      int cyc;
   } ev_t;

   ev_t sb_q[$];
   ev_t mon_e;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [2:0] last_ph = 3'd0;

   // Expected program tables, indexed by mode.
   int fill_t[4]  = '{0, 2, 4, 8};
   int wash_t[4]  = '{0, 4, 6, 8};
   int rinse_t[4] = '{0, 3, 4, 5};
   int wl_t[4]    = '{0, 8'h03, 8'h0F, 8'hFF};

`ifdef WASH_SEQ_OVERTIME_EN
   localparam int OT_ONE = 1;
   localparam int OT_SAT = 255;
`else
   localparam int OT_ONE = 0;
   localparam int OT_SAT = 0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push_ev(input int ph, input int sec, input int wl, input int c);
      ev_t e;
      e.ph  = ph;
      e.sec = sec;
      e.wl  = wl;
      e.cyc = c;
      sb_q.push_back(e);
   endtask

   // Full program from the start edge t0; extra = clocks spent paused in WASH.
   task automatic expect_run(input int m, input int t0, input int extra);
      int c;
      c = t0;
      if (m == 0) begin
         push_ev(4, 3, 0, c);
         push_ev(5, 0, 0, c + 3 * TD);
      end else begin
         push_ev(1, fill_t[m], 0, c);
         c = c + fill_t[m] * TD;
         push_ev(2, wash_t[m], wl_t[m], c);
         c = c + wash_t[m] * TD + extra;
         push_ev(3, rinse_t[m], wl_t[m], c);
         c = c + rinse_t[m] * TD;
         push_ev(4, 3, 0, c);
         c = c + 3 * TD;
         push_ev(5, 0, 0, c);
      end
   endtask

   // Drive a start pulse; returns the edge number that accepted it.
   task automatic do_start(input logic [1:0] m, output int t0);
      mode  = m;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      t0 = cyc;
   endtask

   task automatic pulse_pause();
      pause = 1'b1;
      @(posedge clk);
      #1;
      pause = 1'b0;
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      @(posedge clk);
      #1;
      ack = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic wait_phase(input logic [2:0] target, input int budget);
      int n;
      n = 0;
      while (phase !== target && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (phase !== target) check("wait_phase_timeout", phase, target);
   endtask

   // Scoreboard monitor: one expected entry per phase change.
   always @(negedge clk) begin
      if (phase != last_ph) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_change", sb_q.size(), 1);
         end else begin
            mon_e = sb_q.pop_front();
            $display("ev phase=%0d sec_left=%0d water=%h cyc=%0d", phase, sec_left, water_lvl, cyc);
            check("ev_phase", phase, mon_e.ph);
            check("ev_cycle", cyc, mon_e.cyc);
            check("ev_sec_left", sec_left, mon_e.sec);
            check("ev_water", water_lvl, mon_e.wl);
         end
         last_ph = phase;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int d;
      start = 1'b0;
      mode  = 2'b00;
      pause = 1'b0;
      abort = 1'b0;
      ack   = 1'b0;
      rst   = 1'b1;
      #1 rst = 1'b0;
      #1;
      check("rst_phase", phase, 0);
      check("rst_sec_left", sec_left, 0);
      check("rst_water", water_lvl, 0);
      check("rst_busy", busy, 0);
      check("rst_paused", paused, 0);
      check("rst_done", done, 0);
      check("rst_overtime", overtime, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Pause and abort in IDLE have no effect.
      pulse_pause();
      check("idle_pause_ignored", paused, 0);
      pulse_abort();
      check("idle_abort_phase", phase, 0);

      // Small program, with a start and an ack sent while busy.
      do_start(2'b01, t0);
      expect_run(1, t0, 0);
      wait_until(t0 + 8);
      mode = 2'b11;
      do_start(2'b11, d);
      check("busy_start_phase", phase, 2);
      check("busy_start_sec", sec_left, 4);
      pulse_ack();
      check("busy_ack_phase", phase, 2);
      check("busy_ack_sec", sec_left, 4);
      wait_phase(3'd5, 100);
      check("small_done", done, 1);
      check("small_busy_low", busy, 0);
      push_ev(0, 0, 0, cyc + 1);
      pulse_ack();
      check("small_ack_idle", phase, 0);

      // Big program paused in WASH at sec_left=5 for 40 clocks.
      do_start(2'b11, t0);
      expect_run(3, t0, 40);
      wait_until(t0 + 44);
      check("pause_at_sec", sec_left, 5);
      pulse_pause();
      check("pause_set", paused, 1);
      wait_until(t0 + 84);
      check("pause_hold_sec", sec_left, 5);
      check("pause_hold_phase", phase, 2);
      check("pause_hold_water", water_lvl, 8'hFF);
      pulse_pause();
      check("pause_clear", paused, 0);
      check("pause_clear_sec", sec_left, 5);
      wait_phase(3'd5, 200);
      push_ev(0, 0, 0, cyc + 1);
      pulse_ack();

      // Medium program aborted in RINSE together with a pause pulse.
      do_start(2'b10, t0);
      push_ev(1, 4, 0, t0);
      push_ev(2, 6, 8'h0F, t0 + 16);
      push_ev(3, 4, 8'h0F, t0 + 40);
      push_ev(0, 0, 0, t0 + 43);
      wait_until(t0 + 42);
      abort = 1'b1;
      pause = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      pause = 1'b0;
      check("abort_phase", phase, 0);
      check("abort_water", water_lvl, 0);
      check("abort_paused", paused, 0);
      check("abort_sec", sec_left, 0);

      // Spin-only program, then overtime in DONE.
      do_start(2'b00, t0);
      expect_run(0, t0, 0);
      wait_until(t0 + 6);
      check("spin_only_water", water_lvl, 0);
      wait_phase(3'd5, 100);
      d = cyc;
      wait_until(d + 4);
      check("overtime_first_tick", overtime, OT_ONE);
      wait_until(d + 1100);
      check("overtime_saturated", overtime, OT_SAT);
      check("done_sec_left", sec_left, 0);
      push_ev(0, 0, 0, cyc + 1);
      pulse_ack();
      check("ack_overtime_clear", overtime, 0);
      check("ack_done_low", done, 0);

      // Reset in the middle of WASH, then a start right after release.
      do_start(2'b01, t0);
      push_ev(1, 2, 0, t0);
      push_ev(2, 4, 8'h03, t0 + 8);
      wait_until(t0 + 12);
      #2;
      rst = 1'b0;
      push_ev(0, 0, 0, cyc + 1);
      #1;
      check("midrst_phase", phase, 0);
      check("midrst_sec", sec_left, 0);
      check("midrst_water", water_lvl, 0);
      check("midrst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b1;
      do_start(2'b00, t0);
      expect_run(0, t0, 0);
      check("post_rst_spin", phase, 4);
      wait_phase(3'd5, 100);
      push_ev(0, 0, 0, cyc + 1);
      pulse_ack();

      repeat (3) @(negedge clk);
      check("sb_leftover", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wash_sequencer.md
WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100000000, giving clk cycles per 1 s tick (minimum 2).
REQ-002 The block SHALL have parameter SPIN_S, default 3, giving the SPIN phase duration in ticks (1..255).
REQ-003 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port start  input  1  single-cycle pulse; begin a cycle using mode.
REQ-006 Port mode  input  2  00 spin-only, 01 small, 10 medium, 11 big; sampled only with an accepted start.
REQ-007 Port pause  input  1  single-cycle pulse; toggle paused while busy.
REQ-008 Port abort  input  1  single-cycle pulse; terminate immediately.
REQ-009 Port ack  input  1  single-cycle pulse; release DONE.
REQ-010 Port phase  output  3  IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, DONE=5.
REQ-011 Port sec_left  output  8  ticks remaining in the current phase (binary).
REQ-012 Port water_lvl  output  8  thermometer water-level lights, LSB first.
REQ-013 Port busy  output  1  high in FILL..SPIN.
REQ-014 Port paused  output  1  pause flag.
REQ-015 Port done  output  1  high in DONE.
REQ-016 Port overtime  output  8  ticks spent in DONE before ack.

Function
REQ-017 The block SHALL contain a prescaler counting 0..TICK_DIV-1 that emits a one-cycle tick at TICK_DIV-1, runs only when (busy and not paused) or in DONE, and clears on an accepted start and on entry to DONE.
REQ-018 An accepted start SHALL occur only in IDLE; it SHALL latch mode and enter FILL on the next clock (SPIN for mode 00); start outside IDLE SHALL be ignored.
REQ-019 The per-mode durations in ticks SHALL be: FILL 2/4/8; WASH 4/6/8; RINSE 3/4/5 (small/medium/big); SPIN is SPIN_S for all modes.
REQ-020 On phase entry, sec_left SHALL load the phase duration; each tick SHALL decrement it; a tick at sec_left==1 SHALL advance FILL->WASH->RINSE->SPIN->DONE and load the next duration in the same edge.
REQ-021 In FILL, each tick SHALL shift a 1 into water_lvl from the LSB; at FILL exit water_lvl SHALL equal 8'h03, 8'h0F, or 8'hFF for small, medium, or big.
REQ-022 water_lvl SHALL hold through WASH and RINSE, and SHALL clear to 0 on SPIN entry.
REQ-023 In DONE, sec_left SHALL be 0; overtime SHALL increment per tick and saturate at 255; ack SHALL return the block to IDLE and clear overtime.
REQ-024 pause SHALL toggle paused only when busy; while paused, phase, sec_left, water_lvl and the prescaler SHALL hold.
REQ-025 If pause and a tick coincide, the tick SHALL be applied and paused SHALL set on the same edge.
REQ-026 abort SHALL force IDLE on the next edge from any state, clearing sec_left, water_lvl, paused, and overtime.
REQ-027 Priority SHALL be abort > ack > pause > tick; in IDLE, abort is ignored.
REQ-028 The block SHALL ignore changes to mode after acceptance.

Reset
REQ-029 On reset assertion, phase SHALL be IDLE and sec_left, water_lvl, overtime, busy, paused, done, prescaler, and latched mode SHALL all be 0, independent of clk.
REQ-030 Reset mid-cycle SHALL discard all progress, and the first edge after release SHALL behave as IDLE.

Configuration
REQ-031 With macro WASH_SEQ_OVERTIME_EN defined, overtime SHALL behave per REQ-023.
REQ-032 Without WASH_SEQ_OVERTIME_EN, overtime SHALL be a constant 0, no overtime counter SHALL exist, and the prescaler SHALL be stopped in DONE.

Verification (TICK_DIV=4, SPIN_S=3)
REQ-033 Reset, then start with mode=01 -> phase sequence FILL(2) WASH(4) RINSE(3) SPIN(3) DONE, 48 clk total; water_lvl=8'h03 at WASH; done=1.
REQ-034 Start with mode=00 -> SPIN, sec_left=3; DONE after 12 clk; water_lvl stays 0.
REQ-035 mode=11, pause during WASH at sec_left=5, wait 40 clk, pause again -> sec_left stays 5 while paused; DONE 40 clk later than the unpaused run.
REQ-036 mode=10, abort in RINSE together with pause -> IDLE next edge, water_lvl=0, paused=0; a following start is accepted.
REQ-037 In DONE, wait 1100 clk, then ack -> overtime saturates at 255 (0 without macro); after ack, IDLE and overtime=0.
REQ-038 Start while busy and ack while busy -> ignored, with no change in phase or sec_left.
